// File: rtl/gray_rgb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : gray_rgb_pkg
// Brief   : RGB565 field widths, FIFO word layout and gray->RGB565 packing.
// Revision: 1.0 - initial release
// ============================================================================
package gray_rgb_pkg;

    localparam int GRAY_W = 8;
    localparam int R_W    = 5;
    localparam int G_W    = 6;
    localparam int B_W    = 5;
    localparam int RGB_W  = R_W + G_W + B_W;
    localparam int TAG_W  = RGB_W + 2;

    typedef struct packed {
        logic             eol;
        logic             sof;
        logic [RGB_W-1:0] rgb;
    } fifo_word_t;

    // Each channel takes the gray MSBs, so white maps to full-scale RGB565.
    function automatic logic [RGB_W-1:0] gray_to_rgb565(input logic [GRAY_W-1:0] g);
        return {g[GRAY_W-1 -: R_W], g[GRAY_W-1 -: G_W], g[GRAY_W-1 -: B_W]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module  : sync_fifo
// Brief   : Single-clock first-word-fall-through FIFO with occupancy count.
// Revision: 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_valid,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;

    logic w_empty;
    logic w_pop;
    logic w_push;

    assign w_empty = (r_count == '0);
    assign w_pop   = i_pop && !w_empty;
    assign w_push  = i_push && ((r_count != (AW+1)'(DEPTH)) || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (w_pop && !w_push) r_count <= r_count - 1'b1;
        end
    end

    // Gate the head so stale memory never leaks out while empty.
    assign o_rdata = w_empty ? '0 : r_mem[r_rptr];
    assign o_valid = !w_empty;
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/gray_rgb565_out.sv
`default_nettype none
// ============================================================================
// Module  : gray_rgb565_out
// Brief   : Gray -> RGB565 return path with binarize, frame tags and FIFO.
// Revision: 1.0 - initial release
// ============================================================================
module gray_rgb565_out
    import gray_rgb_pkg::*;
#(
    parameter int H_PIXELS   = 640,
    parameter int V_LINES    = 480,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              tft_clk,
    input  logic              tft_rst,
    input  logic [GRAY_W-1:0] gray_ip_data,
    input  logic              gray_ip_flag,
    input  logic              gray_ip_sof,
    output logic              gray_ip_ready,
    input  logic              bin_en,
    input  logic [GRAY_W-1:0] bin_thresh,
    output logic [RGB_W-1:0]  rgb_op_data,
    output logic              rgb_op_flag,
    input  logic              rgb_op_ready,
    output logic              rgb_op_sof,
    output logic              rgb_op_eol
);

    localparam int XW = $clog2(H_PIXELS);
    localparam int YW = $clog2(V_LINES);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [XW-1:0]     r_x;
    logic [YW-1:0]     r_y;
    logic              r_ready;
    logic              r_s1_valid;
    logic [GRAY_W-1:0] r_s1_gray;
    logic              r_s1_sof;
    logic              r_s1_eol;
    logic              r_s2_valid;
    fifo_word_t        r_s2_word;

    logic              w_accept;
    logic              w_pop;
    logic [XW-1:0]     w_tx;
    logic [YW-1:0]     w_ty;
    logic              w_x_last;
    logic              w_y_last;
    logic [GRAY_W-1:0] w_g1;
    logic [TAG_W-1:0]  w_rdata;
    fifo_word_t        w_head;
    logic              w_valid;
    logic [CW-1:0]     w_count;
    logic [CW:0]       w_occ_next;

    assign w_accept = gray_ip_flag && r_ready;
    assign w_pop    = w_valid && rgb_op_ready;

    assign w_tx     = gray_ip_sof ? '0 : r_x;
    assign w_ty     = gray_ip_sof ? '0 : r_y;
    assign w_x_last = (w_tx == XW'(H_PIXELS - 1));
    assign w_y_last = (w_ty == YW'(V_LINES - 1));
    assign w_g1     = bin_en ? ((gray_ip_data >= bin_thresh) ? 8'hFF : 8'h00) : gray_ip_data;

    // Next-cycle occupancy including in-flight pixels; registering ready from
    // next-state values keeps the FIFO from ever being written when full.
    assign w_occ_next = {1'b0, w_count} + (CW+1)'(r_s2_valid) - (CW+1)'(w_pop)
                      + (CW+1)'(w_accept) + (CW+1)'(r_s1_valid);

    always_ff @(posedge tft_clk or negedge tft_rst) begin
        if (!tft_rst) begin
            r_x        <= '0;
            r_y        <= '0;
            r_ready    <= 1'b0;
            r_s1_valid <= 1'b0;
            r_s1_gray  <= '0;
            r_s1_sof   <= 1'b0;
            r_s1_eol   <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s2_word  <= '0;
        end else begin
            r_ready    <= (w_occ_next <= (CW+1)'(FIFO_DEPTH - 1));
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_gray <= w_g1;
                r_s1_sof  <= (w_tx == '0) && (w_ty == '0);
                r_s1_eol  <= w_x_last;
                r_x       <= w_x_last ? '0 : w_tx + 1'b1;
                r_y       <= w_x_last ? (w_y_last ? '0 : w_ty + 1'b1) : w_ty;
            end
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_word.eol <= r_s1_eol;
                r_s2_word.sof <= r_s1_sof;
                r_s2_word.rgb <= gray_to_rgb565(r_s1_gray);
            end
        end
    end

    sync_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (tft_clk),
        .rst_n   (tft_rst),
        .i_push  (r_s2_valid),
        .i_wdata (r_s2_word),
        .i_pop   (rgb_op_ready),
        .o_rdata (w_rdata),
        .o_valid (w_valid),
        .o_count (w_count)
    );

    assign w_head        = w_rdata;
    assign gray_ip_ready = r_ready;
    assign rgb_op_data   = w_head.rgb;
    assign rgb_op_sof    = w_head.sof;
    assign rgb_op_eol    = w_head.eol;
    assign rgb_op_flag   = w_valid;

endmodule
`default_nettype wire

// File: tb/tb_gray_rgb565_out.sv
`default_nettype none
// ============================================================================
// Module  : tb_gray_rgb565_out
// Brief   : Directed + randomized self-checking bench with a pixel scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
module tb_gray_rgb565_out;

    localparam int TB_H = 16;
    localparam int TB_V = 4;
    localparam int TB_D = 16;

    logic        clk = 1'b0;
    logic        tft_rst = 1'b0;
    logic [7:0]  gray_ip_data = '0;
    logic        gray_ip_flag = 1'b0;
    logic        gray_ip_sof = 1'b0;
    logic        gray_ip_ready;
    logic        bin_en = 1'b0;
    logic [7:0]  bin_thresh = '0;
    logic [15:0] rgb_op_data;
    logic        rgb_op_flag;
    logic        rgb_op_ready = 1'b0;
    logic        rgb_op_sof;
    logic        rgb_op_eol;

    int n_checks = 0;
    int n_errors = 0;

    logic [17:0] q[$];
    int          mx = 0, my = 0, tx, ty;
    int          pops = 0, accepts = 0;
    bit          frame_mode = 0;
    int          fidx = 0;
    logic [7:0]  g;
    logic [17:0] exp_w;

    always #5 clk = ~clk;

    gray_rgb565_out #(
        .H_PIXELS   (TB_H),
        .V_LINES    (TB_V),
        .FIFO_DEPTH (TB_D)
    ) dut (
        .tft_clk       (clk),
        .tft_rst       (tft_rst),
        .gray_ip_data  (gray_ip_data),
        .gray_ip_flag  (gray_ip_flag),
        .gray_ip_sof   (gray_ip_sof),
        .gray_ip_ready (gray_ip_ready),
        .bin_en        (bin_en),
        .bin_thresh    (bin_thresh),
        .rgb_op_data   (rgb_op_data),
        .rgb_op_flag   (rgb_op_flag),
        .rgb_op_ready  (rgb_op_ready),
        .rgb_op_sof    (rgb_op_sof),
        .rgb_op_eol    (rgb_op_eol)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: model accepted pixels, compare every popped head.
    always @(negedge clk) begin
        if (!tft_rst) begin
            q.delete();
            mx = 0;
            my = 0;
        end else begin
            if (rgb_op_flag && rgb_op_ready) begin
                if (q.size() == 0) begin
                    check_val("pop_unexpected", 1, 0);
                end else begin
                    exp_w = q.pop_front();
                    check_val("head", {rgb_op_eol, rgb_op_sof, rgb_op_data}, exp_w);
                end
                if (frame_mode) begin
                    check_val("frame_sof", rgb_op_sof, ((fidx % (TB_H*TB_V)) == 0));
                    check_val("frame_eol", rgb_op_eol, ((fidx % TB_H) == TB_H-1));
                    fidx++;
                end
                pops++;
            end
            if (gray_ip_flag && gray_ip_ready) begin
                tx = gray_ip_sof ? 0 : mx;
                ty = gray_ip_sof ? 0 : my;
                g  = bin_en ? ((gray_ip_data >= bin_thresh) ? 8'hFF : 8'h00) : gray_ip_data;
                q.push_back({(tx == TB_H-1), (tx == 0 && ty == 0), g[7:3], g[7:2], g[7:3]});
                mx = (tx == TB_H-1) ? 0 : tx + 1;
                my = (tx == TB_H-1) ? ((ty == TB_V-1) ? 0 : ty + 1) : ty;
                accepts++;
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic s);
        int n = 0;
        gray_ip_data = d;
        gray_ip_sof  = s;
        gray_ip_flag = 1'b1;
        @(negedge clk);
        while (!gray_ip_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) check_val("send_timeout", 1, 0);
        @(posedge clk); #1;
        gray_ip_flag = 1'b0;
        gray_ip_sof  = 1'b0;
    endtask

    task automatic expect_head(input string tag, input logic [17:0] exp);
        int n = 0;
        @(negedge clk);
        while (!rgb_op_flag && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_val(tag, {rgb_op_eol, rgb_op_sof, rgb_op_data}, exp);
        @(posedge clk); #1;
        rgb_op_ready = 1'b1;
        @(posedge clk); #1;
        rgb_op_ready = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        rgb_op_ready = 1'b1;
        gray_ip_flag = 1'b0;
        while ((q.size() != 0 || rgb_op_flag) && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        check_val("drain", q.size(), 0);
    endtask

    task automatic fill_blocked(input int cycles);
        rgb_op_ready = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            gray_ip_flag = 1'b1;
            gray_ip_data = 8'(i * 7 + 3);
        end
        @(posedge clk); #1;
        gray_ip_flag = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        int p0, cyc;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_ready", gray_ip_ready, 0);
        check_val("rst_flag", rgb_op_flag, 0);
        check_val("rst_word", {rgb_op_eol, rgb_op_sof, rgb_op_data}, 0);
        tft_rst = 1'b1;
        @(posedge clk); #1;
        check_val("rst_ready_up", gray_ip_ready, 1);

        // Latency and basic expansion (first pixel after reset is (0,0))
        send(8'hA5, 1'b0);
        check_val("lat0", rgb_op_flag, 0);
        @(posedge clk); #1;
        check_val("lat1", rgb_op_flag, 0);
        @(posedge clk); #1;
        check_val("lat2", rgb_op_flag, 1);
        check_val("lat2_data", rgb_op_data, 16'hA534);
        expect_head("a5_word", 18'h1A534);

        // Binarization around the threshold
        bin_en = 1'b1;
        bin_thresh = 8'h80;
        send(8'h7F, 1'b0);
        send(8'h80, 1'b0);
        send(8'hFF, 1'b0);
        bin_en = 1'b0;
        expect_head("bin_7f", 18'h00000);
        expect_head("bin_80", 18'h0FFFF);
        expect_head("bin_ff", 18'h0FFFF);

        // Two frames plus one pixel: sof only at frame starts, eol every line
        rgb_op_ready = 1'b1;
        frame_mode = 1;
        fidx = 0;
        for (int i = 0; i < 2*TB_H*TB_V + 1; i++) send(8'(i), (i == 0));
        drain();
        frame_mode = 0;
        check_val("frame_count", fidx, 2*TB_H*TB_V + 1);

        // Backpressure: exactly FIFO_DEPTH held, then 1 pixel/clk drain
        fill_blocked(25);
        check_val("hold_ready", gray_ip_ready, 0);
        check_val("hold_count", q.size(), TB_D);
        check_val("hold_flag", rgb_op_flag, 1);
        p0 = pops;
        rgb_op_ready = 1'b1;
        repeat (TB_D) @(posedge clk);
        #1;
        check_val("rel_rate", pops - p0, TB_D);
        check_val("rel_empty", rgb_op_flag, 0);
        check_val("rel_ready", gray_ip_ready, 1);

        // Random flag/ready/binarize/sof against the scoreboard
        p0 = accepts;
        cyc = 0;
        while ((accepts - p0) < 10000 && cyc < 60000) begin
            @(posedge clk); #1;
            gray_ip_flag = ($urandom_range(0, 3) != 0);
            gray_ip_data = 8'($urandom);
            gray_ip_sof  = ($urandom_range(0, 63) == 0);
            bin_en       = ($urandom_range(0, 3) == 0);
            bin_thresh   = 8'($urandom);
            rgb_op_ready = ($urandom_range(0, 3) != 0);
            cyc++;
        end
        check_val("rand_budget", ((accepts - p0) >= 10000), 1);
        @(posedge clk); #1;
        gray_ip_sof = 1'b0;
        bin_en = 1'b0;
        drain();

        // Mid-line reset with a full FIFO
        fill_blocked(25);
        check_val("full_before_rst", rgb_op_flag, 1);
        @(posedge clk); #3;
        tft_rst = 1'b0;
        #1;
        check_val("arst_flag", rgb_op_flag, 0);
        check_val("arst_word", {rgb_op_eol, rgb_op_sof, rgb_op_data}, 0);
        check_val("arst_ready", gray_ip_ready, 0);
        repeat (2) @(posedge clk);
        #1;
        tft_rst = 1'b1;
        @(posedge clk); #1;
        check_val("post_rst_ready", gray_ip_ready, 1);
        check_val("post_rst_flag", rgb_op_flag, 0);
        send(8'h3C, 1'b1);
        send(8'h10, 1'b0);
        expect_head("post_rst_p0", 18'h139E7);
        expect_head("post_rst_p1", 18'h01082);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
